card_dealer: RTL and testbench

Draws playing cards without replacement from a single 52-card deck, using the free-running value produced by the `rng` stage as its entropy source. It sits directly downstream of `rng` and upstream of the blackjack game controller. It converts each accepted random sample into a unique card (rank, suit, blackjack points). It also tracks the deck state (cards remaining, empty) and supports a single-cycle reshuffle.

---
 rtl/card_dealer_if.sv | 24 ++
 rtl/card_dealer.sv | 122 ++++++++++++
 tb/tb_card_dealer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Request/response bundle between the card dealer, its rng source and the game controller.
// master: the consumer that requests cards; slave: the dealer itself.
interface card_dealer_if;
  logic [5:0] rand_val;
  logic       deal_req;
  logic       shuffle;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_points;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       busy;

  modport master (
    output rand_val, deal_req, shuffle,
    input  card_valid, card_rank, card_suit, card_points, cards_left, deck_empty, busy
  );

  modport slave (
    input  rand_val, deal_req, shuffle,
    output card_valid, card_rank, card_suit, card_points, cards_left, deck_empty, busy
  );
endinterface

// File: rtl/card_dealer.sv
// Deals cards without replacement from one 52-card deck, drawing entropy from rand_val.
// Rejects samples >= 52 and resolves collisions by linear probing with wrap at 51.
module card_dealer #(
  parameter logic [3:0] ACE_POINTS  = 4'd11,
  parameter logic [3:0] FACE_POINTS = 4'd10
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  card_dealer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SAMPLE, PROBE} state_t;

  state_t      state_reg;
  logic [51:0] used_reg;
  logic [5:0]  idx_reg;
  logic [5:0]  cards_left_reg;
  logic        deck_empty_reg;
  logic        busy_reg;
  logic        card_valid_reg;
  logic [3:0]  card_rank_reg;
  logic [1:0]  card_suit_reg;
  logic [3:0]  card_points_reg;

  logic [5:0]  suit_base;
  logic [1:0]  suit_dec;
  logic [3:0]  rank_dec;
  logic [3:0]  points_dec;
  logic [5:0]  idx_wrap;
  logic        slot_used;

  // Suit/rank split by comparing against the suit boundaries instead of dividing.
  always_comb begin
    suit_dec  = 2'd0;
    suit_base = 6'd0;
    if (idx_reg >= 6'd39) begin
      suit_dec  = 2'd3;
      suit_base = 6'd39;
    end else if (idx_reg >= 6'd26) begin
      suit_dec  = 2'd2;
      suit_base = 6'd26;
    end else if (idx_reg >= 6'd13) begin
      suit_dec  = 2'd1;
      suit_base = 6'd13;
    end
    rank_dec = 4'(idx_reg - suit_base) + 4'd1;
    if (rank_dec == 4'd1) begin
      points_dec = ACE_POINTS;
    end else if (rank_dec >= 4'd11) begin
      points_dec = FACE_POINTS;
    end else begin
      points_dec = rank_dec;
    end
    idx_wrap  = (idx_reg == 6'd51) ? 6'd0 : idx_reg + 6'd1;
    slot_used = used_reg[idx_reg];
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      used_reg        <= '0;
      idx_reg         <= '0;
      cards_left_reg  <= 6'd52;
      deck_empty_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      card_valid_reg  <= 1'b0;
      card_rank_reg   <= '0;
      card_suit_reg   <= '0;
      card_points_reg <= '0;
    end else begin
      card_valid_reg <= 1'b0;
      // Shuffle wins over everything, including an in-flight draw.
      if (bus.shuffle) begin
        state_reg      <= IDLE;
        used_reg       <= '0;
        cards_left_reg <= 6'd52;
        deck_empty_reg <= 1'b0;
        busy_reg       <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.deal_req && !deck_empty_reg) begin
              state_reg <= SAMPLE;
              busy_reg  <= 1'b1;
            end
          end
          SAMPLE: begin
            if (bus.rand_val < 6'd52) begin
              idx_reg   <= bus.rand_val;
              state_reg <= PROBE;
            end
          end
          PROBE: begin
            if (!slot_used) begin
              used_reg[idx_reg] <= 1'b1;
              cards_left_reg    <= cards_left_reg - 6'd1;
              deck_empty_reg    <= (cards_left_reg == 6'd1);
              card_rank_reg     <= rank_dec;
              card_suit_reg     <= suit_dec;
              card_points_reg   <= points_dec;
              card_valid_reg    <= 1'b1;
              busy_reg          <= 1'b0;
              state_reg         <= IDLE;
            end else begin
              idx_reg <= idx_wrap;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.card_valid  = card_valid_reg;
  assign bus.card_rank   = card_rank_reg;
  assign bus.card_suit   = card_suit_reg;
  assign bus.card_points = card_points_reg;
  assign bus.cards_left  = cards_left_reg;
  assign bus.deck_empty  = deck_empty_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a deck model predicts each card and its timing, checked every cycle.
module tb_card_dealer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  card_dealer_if bus();

  card_dealer dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  bit         used_m [52];
  int         exp_left;
  logic       exp_valid;
  logic       exp_busy;
  logic [3:0] exp_rank;
  logic [1:0] exp_suit;
  logic [3:0] exp_points;
  bit         check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("card_valid",  32'(bus.card_valid),  32'(exp_valid));
      check("busy",        32'(bus.busy),        32'(exp_busy));
      check("cards_left",  32'(bus.cards_left),  32'(exp_left));
      check("deck_empty",  32'(bus.deck_empty),  32'(exp_left == 0));
      check("card_rank",   32'(bus.card_rank),   32'(exp_rank));
      check("card_suit",   32'(bus.card_suit),   32'(exp_suit));
      check("card_points", 32'(bus.card_points), 32'(exp_points));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    foreach (used_m[i]) used_m[i] = 1'b0;
    exp_left = 52;
  endtask

  function automatic logic [3:0] points_of(input int rank);
    if (rank == 1) return 4'd11;
    if (rank > 10) return 4'd10;
    return 4'(rank);
  endfunction

  // One full draw: rejects bad samples first, then rv. Returns edges from request to card_valid.
  task automatic do_deal(input int rejects, input int rv, output int lat, output int idx_out);
    int p;
    int probes;
    bus.deal_req = 1'b1;
    bus.rand_val = (rejects > 0) ? 6'd60 : 6'(rv);
    tick();
    bus.deal_req = 1'b0;
    exp_busy = 1'b1;
    lat = 1;
    for (int r = 0; r < rejects; r++) begin
      tick();
      lat++;
    end
    bus.rand_val = 6'(rv);
    tick();
    lat++;
    p = rv;
    probes = 0;
    while (used_m[p] && probes < 52) begin
      p = (p + 1) % 52;
      probes++;
    end
    for (int k = 0; k < probes; k++) begin
      tick();
      lat++;
    end
    tick();
    lat++;
    used_m[p]  = 1'b1;
    exp_left   = exp_left - 1;
    exp_valid  = 1'b1;
    exp_busy   = 1'b0;
    exp_rank   = 4'(p % 13 + 1);
    exp_suit   = 2'(p / 13);
    exp_points = points_of(p % 13 + 1);
    idx_out    = p;
    $display("deal rv=%0d rejects=%0d -> idx %0d rank %0d suit %0d latency %0d left %0d",
             rv, rejects, p, exp_rank, exp_suit, lat, exp_left);
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic do_shuffle(input logic with_deal);
    bus.shuffle  = 1'b1;
    bus.deal_req = with_deal;
    tick();
    bus.shuffle  = 1'b0;
    bus.deal_req = 1'b0;
    model_clear();
    exp_busy  = 1'b0;
    exp_valid = 1'b0;
    $display("shuffle (deal_req=%0b) -> left %0d", with_deal, exp_left);
  endtask

  task automatic model_reset();
    model_clear();
    exp_valid  = 1'b0;
    exp_busy   = 1'b0;
    exp_rank   = '0;
    exp_suit   = '0;
    exp_points = '0;
  endtask

  bit seen [64];
  int lat;
  int idx;
  int distinct;

  initial begin
    resetn       = 1'b0;
    bus.rand_val = '0;
    bus.deal_req = 1'b0;
    bus.shuffle  = 1'b0;
    model_reset();
    tick();
    check_en = 1'b1;
    tick();
    resetn = 1'b1;
    tick();

    // Reset mid-draw, then best-case deal with rand_val=5.
    bus.rand_val = 6'd63;
    bus.deal_req = 1'b1;
    tick();
    bus.deal_req = 1'b0;
    exp_busy = 1'b1;
    tick();
    resetn = 1'b0;
    model_reset();
    #1;
    check("reset_left", 32'(bus.cards_left), 32'd52);
    check("reset_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    $display("reset applied mid-draw");
    tick();
    do_deal(0, 5, lat, idx);
    check("best_latency", 32'(lat), 32'd3);
    check("best_rank",    32'(bus.card_rank), 32'd6);
    check("best_suit",    32'(bus.card_suit), 32'd0);
    check("best_points",  32'(bus.card_points), 32'd6);
    check("best_left",    32'(bus.cards_left), 32'd51);

    // Three rejected samples then 38.
    do_deal(3, 38, lat, idx);
    check("rej_latency", 32'(lat), 32'd6);
    check("rej_rank",    32'(bus.card_rank), 32'd13);
    check("rej_suit",    32'(bus.card_suit), 32'd2);
    check("rej_points",  32'(bus.card_points), 32'd10);

    // Collision at 51 wraps to 0.
    do_deal(0, 51, lat, idx);
    check("k3_rank", 32'(bus.card_rank), 32'd13);
    check("k3_suit", 32'(bus.card_suit), 32'd3);
    do_deal(0, 51, lat, idx);
    check("wrap_latency", 32'(lat), 32'd4);
    check("wrap_rank",    32'(bus.card_rank), 32'd1);
    check("wrap_suit",    32'(bus.card_suit), 32'd0);
    check("wrap_points",  32'(bus.card_points), 32'd11);

    // Shuffle aborts a draw stuck in SAMPLE.
    bus.rand_val = 6'd63;
    bus.deal_req = 1'b1;
    tick();
    bus.deal_req = 1'b0;
    exp_busy = 1'b1;
    tick();
    do_shuffle(1'b0);
    tick();
    tick();
    check("abort_left", 32'(bus.cards_left), 32'd52);
    check("abort_busy", 32'(bus.busy), 32'd0);

    // Occupy slot 0, then shuffle and deal collide in IDLE.
    do_deal(0, 0, lat, idx);
    do_shuffle(1'b1);
    tick();
    check("collide_busy", 32'(bus.busy), 32'd0);
    check("collide_left", 32'(bus.cards_left), 32'd52);

    // Slot 0 is free again after the shuffle.
    do_deal(0, 0, lat, idx);
    check("post_shuffle_latency", 32'(lat), 32'd3);
    check("post_shuffle_rank",    32'(bus.card_rank), 32'd1);

    // Drain the whole deck.
    do_shuffle(1'b0);
    foreach (seen[i]) seen[i] = 1'b0;
    for (int n = 0; n < 52; n++) begin
      do_deal(int'($urandom_range(0, 1)), int'($urandom_range(0, 51)), lat, idx);
      seen[{bus.card_suit, bus.card_rank}] = 1'b1;
    end
    distinct = 0;
    foreach (seen[i]) if (seen[i]) distinct++;
    check("distinct_cards", 32'(distinct), 32'd52);
    check("empty_flag",     32'(bus.deck_empty), 32'd1);

    // Request on an empty deck is ignored.
    bus.deal_req = 1'b1;
    tick();
    bus.deal_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("empty_busy",  32'(bus.busy), 32'd0);
    check("empty_valid", 32'(bus.card_valid), 32'd0);
    $display("deal on empty deck ignored");

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
